cla_carry_sum_pipe: RTL and testbench
=====================================

// Module: cla_carry_sum_pipe
// PURPOSE
//   Carry-lookahead and sum stage that consumes the per-bit propagate/generate vectors from the
//   WIDTH-wide pg_block array. Produces the registered sum, carry-out, signed overflow and group P/G.
//   Two-stage valid/ready pipeline: S1 captures P/G/Cin, S2 registers lookahead results.
//   Sits between the pg_block array and the adder result consumer.
// PARAMETERS
//   WIDTH   5   operand width in bits; legal range 2..16
// PORTS
//   clk        in   1      single clock; all state updates on its rising edge
//   rst        in   1      asynchronous, active-high reset
//   in_valid   in   1      p_vec/g_vec/cin hold a valid operation
//   in_ready   out  1      S1 can accept this cycle
//   p_vec      in   WIDTH  per-bit propagate (A^B) from the pg_block array
//   g_vec      in   WIDTH  per-bit generate (A&B) from the pg_block array
//   cin        in   1      carry-in
//   out_valid  out  1      sum/cout/ovf/grp_p/grp_g valid
//   out_ready  in   1      consumer accepts the result this cycle
//   sum        out  WIDTH  p_vec ^ c[WIDTH-1:0]
//   cout       out  1      c[WIDTH]
//   ovf        out  1      signed overflow = c[WIDTH] ^ c[WIDTH-1]
//   grp_p      out  1      &p_vec (whole-word propagate)
//   grp_g      out  1      whole-word generate, i.e. the carry-out when cin=0
// BEHAVIOUR
//   Reset (rst=1, asynchronous): s1_valid=0, out_valid=0, and all data registers set to 0.
//     Outputs during and after reset: sum=0, cout=0, ovf=0, grp_p=0, grp_g=0.
//     Reset asserted mid-operation drops in-flight data without producing any output.
//   Carries: c[0]=cin; c[i+1]=g[i] | (p[i] & c[i]). The expression is flattened lookahead logic,
//     not a ripple chain. The equations hold for any input, including p[i]&g[i]=1.
//   Handshake: an input transfer occurs when in_valid & in_ready.
//     An output transfer occurs when out_valid & out_ready.
//   adv2 = ~out_valid | out_ready
//     On adv2, S2 loads from S1: out_valid<=s1_valid; data loads only when s1_valid=1.
//   in_ready = ~s1_valid | adv2 (combinational; in_ready does not depend on in_valid).
//     On an input transfer, S1 captures p_vec, g_vec and cin, and s1_valid<=1.
//     When in_ready=1 and in_valid=0, s1_valid<=0.
//   Latency is 2 cycles from input transfer to out_valid. Throughput is 1 op/cycle when out_ready=1.
//   Stall: while out_valid & ~out_ready, all outputs hold stable.
//     S1 holds its data; in_ready = ~s1_valid, so at most 2 operations are buffered.
//   Simultaneous events: an input transfer, S1->S2 move and output transfer in one cycle are all
//     legal; no bubble is inserted. An input held with in_ready=0 must stay stable (caller rule).
//   Inputs are not checked. Data is never dropped or duplicated; outputs emerge in order.
// TESTING (WIDTH=5)
//   1. Reset: rst=1, then released; hold in_valid=0
//      -> out_valid=0, sum=0, cout=0, ovf=0 and in_ready=1 in the cycle after release.
//   2. A=11, B=6 (p=01101, g=00010, cin=0)
//      -> 2 cycles later: sum=10001, cout=0, ovf=1, grp_p=0, grp_g=0.
//   3. A=31, B=1 (p=11110, g=00001, cin=0) -> sum=00000, cout=1, ovf=0, grp_p=0, grp_g=1.
//   4. A=31, B=0, cin=1 (p=11111, g=0) -> sum=00000, cout=1, ovf=0, grp_p=1, grp_g=0 (full chain).
//   5. Back-pressure: stream 4 ops with out_ready=0
//      -> in_ready drops after 2 accepts; outputs hold.
//      Then set out_ready=1 -> all 4 results emerge in order, none lost or duplicated.
//   6. Reset with 2 ops in flight -> out_valid=0 immediately (asynchronous); no stale result after.

Source files
------------

// File: rtl/cla_carry_sum_pipe.sv
// Carry-lookahead sum stage: P/G/Cin captured in S1, sum/cout/ovf/group P-G registered in S2.
// Latency 2 cycles, 1 op/cycle; a stalled consumer backs up both stages, then drops in_ready.
module cla_carry_sum_pipe #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] p_vec,
  input  logic [WIDTH-1:0] g_vec,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             grp_p,
  output logic             grp_g
);

  logic             s1_valid;
  logic [WIDTH-1:0] s1_p;
  logic [WIDTH-1:0] s1_g;
  logic             s1_cin;
  logic             adv2;
  logic [WIDTH:0]   c;
  logic             grp_g_nxt;

  // AND of p[hi:lo]; an empty span (lo > hi) is 1.
  function automatic logic span_and(input logic [WIDTH-1:0] p, input int lo, input int hi);
    logic r;
    r = 1'b1;
    for (int k = 0; k < WIDTH; k++) begin
      if (k >= lo && k <= hi) r = r & p[k];
    end
    return r;
  endfunction

  // Two-level sum-of-products per carry: c[i+1] = p[i:0]&cin | OR_j g[j]&p[i:j+1].
  function automatic logic [WIDTH:0] lookahead(input logic [WIDTH-1:0] p,
                                               input logic [WIDTH-1:0] g,
                                               input logic ci);
    logic [WIDTH:0] cv;
    cv    = '0;
    cv[0] = ci;
    for (int i = 0; i < WIDTH; i++) begin
      cv[i+1] = span_and(p, 0, i) & ci;
      for (int j = 0; j <= i; j++) begin
        cv[i+1] = cv[i+1] | (g[j] & span_and(p, j + 1, i));
      end
    end
    return cv;
  endfunction

  function automatic logic group_gen(input logic [WIDTH-1:0] p, input logic [WIDTH-1:0] g);
    logic r;
    r = 1'b0;
    for (int j = 0; j < WIDTH; j++) begin
      r = r | (g[j] & span_and(p, j + 1, WIDTH - 1));
    end
    return r;
  endfunction

  always_comb begin
    adv2      = ~out_valid | out_ready;
    in_ready  = ~s1_valid | adv2;
    c         = lookahead(s1_p, s1_g, s1_cin);
    grp_g_nxt = group_gen(s1_p, s1_g);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_p     <= '0;
      s1_g     <= '0;
      s1_cin   <= 1'b0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_p   <= p_vec;
        s1_g   <= g_vec;
        s1_cin <= cin;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      grp_p     <= 1'b0;
      grp_g     <= 1'b0;
    end else if (adv2) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        sum   <= s1_p ^ c[WIDTH-1:0];
        cout  <= c[WIDTH];
        ovf   <= c[WIDTH] ^ c[WIDTH-1];
        grp_p <= &s1_p;
        grp_g <= grp_g_nxt;
      end
    end
  end

endmodule

// File: tb/tb_cla_carry_sum_pipe.sv
// Bench for cla_carry_sum_pipe (WIDTH=5): vector table, latency, back-pressure, async reset, random stream.
module tb_cla_carry_sum_pipe;

  localparam int W = 5;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] p_vec;
  logic [W-1:0] g_vec;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic         grp_p;
  logic         grp_g;

  cla_carry_sum_pipe #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .p_vec(p_vec), .g_vec(g_vec), .cin(cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf), .grp_p(grp_p), .grp_g(grp_g)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] p;
    logic [W-1:0] g;
    logic         cin;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         gp;
    logic         gg;
  } vec_t;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         gp;
    logic         gg;
  } exp_t;

  vec_t tbl [8];
  exp_t sb [$];
  exp_t cur_exp;
  exp_t bp_exp [4];
  logic xfer_in;
  int   n_chk  = 0;
  int   n_fail = 0;
  int   n_out  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Arithmetic reference: operands A/B, independent of the carry equations.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
    exp_t e;
    logic [W:0] s;
    logic [W:0] s0;
    s    = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
    s0   = {1'b0, a} + {1'b0, b};
    e.sum  = s[W-1:0];
    e.cout = s[W];
    e.ovf  = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
    e.gp   = &(a ^ b);
    e.gg   = s0[W];
    return e;
  endfunction

  task automatic drive_vec(input vec_t v);
    in_valid = 1'b1;
    p_vec = v.p; g_vec = v.g; cin = v.cin;
    cur_exp = '{v.sum, v.cout, v.ovf, v.gp, v.gg};
  endtask

  task automatic drive_ab(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
    in_valid = 1'b1;
    p_vec = a ^ b; g_vec = a & b; cin = ci;
    cur_exp = model(a, b, ci);
  endtask

  // One cycle: sample handshakes mid low phase, score output, record input, advance to next negedge.
  task automatic tick();
    exp_t e;
    #1;
    xfer_in = in_valid && in_ready;
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL unexpected_output: got sum=%b cout=%b, expected no output", sum, cout);
      end else begin
        e = sb.pop_front();
        chk("sum", sum, e.sum);
        chk("cout", cout, e.cout);
        chk("ovf", ovf, e.ovf);
        chk("grp_p", grp_p, e.gp);
        chk("grp_g", grp_g, e.gg);
        n_out++;
      end
    end
    if (xfer_in) sb.push_back(cur_exp);
    @(negedge clk);
  endtask

  task automatic drain();
    int n;
    n = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while ((sb.size() != 0 || out_valid) && n < 40) begin
      tick();
      n++;
    end
    if (n >= 40) begin
      n_chk++; n_fail++;
      $display("FAIL drain_timeout: %0d results pending, expected 0", sb.size());
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, idx, base;
    //              p         g         cin   sum       cout  ovf   gp    gg
    tbl[0] = '{5'b01101, 5'b00010, 1'b0, 5'b10001, 1'b0, 1'b1, 1'b0, 1'b0}; // 11+6
    tbl[1] = '{5'b11110, 5'b00001, 1'b0, 5'b00000, 1'b1, 1'b0, 1'b0, 1'b1}; // 31+1
    tbl[2] = '{5'b11111, 5'b00000, 1'b1, 5'b00000, 1'b1, 1'b0, 1'b1, 1'b0}; // 31+0+1
    tbl[3] = '{5'b01110, 5'b00001, 1'b0, 5'b10000, 1'b0, 1'b1, 1'b0, 1'b0}; // 15+1
    tbl[4] = '{5'b00000, 5'b10000, 1'b0, 5'b00000, 1'b1, 1'b1, 1'b0, 1'b1}; // 16+16
    tbl[5] = '{5'b00000, 5'b00000, 1'b1, 5'b00001, 1'b0, 1'b0, 1'b0, 1'b0}; // 0+0+1
    tbl[6] = '{5'b11111, 5'b11111, 1'b0, 5'b00001, 1'b1, 1'b0, 1'b1, 1'b1}; // p&g both set
    tbl[7] = '{5'b11111, 5'b00000, 1'b0, 5'b11111, 1'b0, 1'b0, 1'b1, 1'b0}; // full propagate, no cin

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    p_vec = '0; g_vec = '0; cin = 1'b0; xfer_in = 1'b0;
    cur_exp = '{5'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    repeat (2) @(negedge clk);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_sum", sum, 5'b0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_out_valid", out_valid, 1'b0);
    chk("post_rst_sum", sum, 5'b0);
    chk("post_rst_cout", cout, 1'b0);
    chk("post_rst_ovf", ovf, 1'b0);
    chk("post_rst_grp", {grp_p, grp_g}, 2'b00);
    chk("post_rst_in_ready", in_ready, 1'b1);

    // Latency of a single op
    drive_vec(tbl[0]);
    tick();
    in_valid = 1'b0;
    chk("lat1_out_valid", out_valid, 1'b0);
    tick();
    chk("lat2_out_valid", out_valid, 1'b1);
    tick();
    drain();

    // Back-to-back stream at full throughput
    for (int i = 1; i < 8; i++) begin
      drive_vec(tbl[i]);
      chk("stream_in_ready", in_ready, 1'b1);
      tick();
    end
    drain();

    // Back-pressure: 4 ops with the consumer stalled
    for (int i = 0; i < 4; i++) bp_exp[i] = model(W'(i * 7 + 3), W'(i * 5 + 9), i[0]);
    base = n_out; acc = 0; idx = 0;
    out_ready = 1'b0;
    drive_ab(W'(3), W'(9), 1'b0);
    for (int c = 0; c < 6; c++) begin
      tick();
      if (xfer_in) begin
        acc++; idx++;
        if (idx < 4) drive_ab(W'(idx * 7 + 3), W'(idx * 5 + 9), idx[0]);
        else in_valid = 1'b0;
      end
      if (c >= 2) begin
        chk("bp_hold_valid", out_valid, 1'b1);
        chk("bp_hold_sum", sum, bp_exp[0].sum);
        chk("bp_hold_cout", cout, bp_exp[0].cout);
      end
    end
    chk("bp_accepts", acc, 2);
    chk("bp_in_ready", in_ready, 1'b0);
    out_ready = 1'b1;
    for (int c = 0; c < 30 && idx < 4; c++) begin
      tick();
      if (xfer_in) begin
        idx++;
        if (idx < 4) drive_ab(W'(idx * 7 + 3), W'(idx * 5 + 9), idx[0]);
        else in_valid = 1'b0;
      end
    end
    drain();
    chk("bp_result_count", n_out - base, 4);

    // Asynchronous reset with two ops in flight
    out_ready = 1'b0;
    drive_ab(W'(12), W'(5), 1'b1);
    tick();
    drive_ab(W'(20), W'(30), 1'b0);
    tick();
    in_valid = 1'b0;
    chk("pre_rst_out_valid", out_valid, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("arst_out_valid", out_valid, 1'b0);
    chk("arst_sum", sum, 5'b0);
    chk("arst_in_ready", in_ready, 1'b1);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (5) tick();
    chk("post_arst_out_valid", out_valid, 1'b0);

    // Random traffic with random back-pressure
    base = n_out; acc = 0;
    in_valid = 1'b0;
    for (int c = 0; c < 80; c++) begin
      if (!(in_valid && !xfer_in)) begin
        if ($urandom_range(0, 3) != 0) begin
          drive_ab(W'($urandom_range(0, 31)), W'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
          acc++;
        end else begin
          in_valid = 1'b0;
        end
      end
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
      if (c == 79 && in_valid && !xfer_in) acc--;
    end
    drain();
    chk("rand_result_count", n_out - base, acc);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
